el2_ifu_ghr_ctl: RTL and testbench

Maintains the speculative (fetch) and retired global branch history registers for the IFU branch predictor. Each fetch-stage conditional-branch prediction shifts its predicted direction into the fetch GHR and records a checkpoint. In-order resolutions from the EXU retire checkpoints into the retired GHR and repair the fetch GHR on a mispredict. The fetch GHR output is the `ghr` input of the BHT index hash, so this block sits directly upstream of the GHR/BTB hash stage.

---
 rtl/el2_ifu_ghr_ctl.sv | 109 ++++++++++
 tb/tb_el2_ifu_ghr_ctl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/el2_ifu_ghr_ctl.sv
`default_nettype none
// ============================================================================
// Module   : el2_ifu_ghr_ctl
// Brief    : Speculative (fetch) and retired global branch history registers
//            with an in-order checkpoint queue of predicted directions.
// Revision : 1.0 - initial release
// ============================================================================
module el2_ifu_ghr_ctl #(
  parameter int GHR_SIZE = 8,
  parameter int DEPTH    = 4,
  parameter int TAGW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                pred_valid,
  input  logic                pred_taken,
  output logic                pred_ready,
  output logic [TAGW-1:0]     pred_tag,
  input  logic                resolve_valid,
  input  logic [TAGW-1:0]     resolve_tag,
  input  logic                resolve_taken,
  input  logic                flush,
  output logic [GHR_SIZE-1:0] fghr,
  output logic [GHR_SIZE-1:0] rghr,
  output logic                redirect,
  output logic [TAGW:0]       count,
  output logic                err
);

  localparam logic [TAGW:0] c_depth = (TAGW+1)'(DEPTH);

  logic [GHR_SIZE-1:0] r_fghr;
  logic [GHR_SIZE-1:0] r_rghr;
  logic [DEPTH-1:0]    r_queue;
  logic [TAGW-1:0]     r_head;
  logic [TAGW-1:0]     r_tail;
  logic [TAGW:0]       r_count;
  logic                r_redirect;
  logic                r_err;

  logic w_accept;
  logic w_res_err;
  logic w_res_ok;
  logic w_mispred;

  function automatic logic [GHR_SIZE-1:0] shift(input logic [GHR_SIZE-1:0] g,
                                                input logic b);
    return {g[GHR_SIZE-2:0], b};
  endfunction

  // Readiness uses registered occupancy only; a same-cycle pop does not free a slot.
  assign pred_ready = (r_count != c_depth);
  assign pred_tag   = r_tail;

  assign w_accept  = pred_valid & pred_ready;
  assign w_res_err = resolve_valid & ((r_count == '0) | (resolve_tag != r_head));
  assign w_res_ok  = resolve_valid & ~w_res_err;
  assign w_mispred = w_res_ok & (resolve_taken != r_queue[r_head]);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_fghr     <= '0;
      r_rghr     <= '0;
      r_queue    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_redirect <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // A flushed resolution is discarded, so it cannot raise a protocol error.
      if (w_res_err && !flush) begin
        r_err <= 1'b1;
      end
      if (flush) begin
        r_fghr     <= r_rghr;
        r_head     <= r_tail;
        r_count    <= '0;
        r_redirect <= 1'b0;
      end else if (w_mispred) begin
        r_rghr     <= shift(r_rghr, resolve_taken);
        r_fghr     <= shift(r_rghr, resolve_taken);
        r_head     <= r_tail;
        r_count    <= '0;
        r_redirect <= 1'b1;
      end else begin
        if (w_res_ok) begin
          r_rghr <= shift(r_rghr, resolve_taken);
          r_head <= r_head + TAGW'(1);
        end
        if (w_accept) begin
          r_fghr          <= shift(r_fghr, pred_taken);
          r_queue[r_tail] <= pred_taken;
          r_tail          <= r_tail + TAGW'(1);
        end
        r_count    <= r_count + (TAGW+1)'(w_accept) - (TAGW+1)'(w_res_ok);
        r_redirect <= 1'b0;
      end
    end
  end

  assign fghr     = r_fghr;
  assign rghr     = r_rghr;
  assign count    = r_count;
  assign redirect = r_redirect;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_el2_ifu_ghr_ctl.sv
`default_nettype none
// Bench for el2_ifu_ghr_ctl: queue-based reference model compared every cycle,
// plus directed scenarios pinned with hand-computed literals.
module tb_el2_ifu_ghr_ctl;
  localparam int GHR_SIZE = 8;
  localparam int DEPTH    = 4;
  localparam int TAGW     = 2;

  logic                clk = 1'b0;
  logic                rst_l = 1'b0;
  logic                pred_valid = 1'b0;
  logic                pred_taken = 1'b0;
  logic                pred_ready;
  logic [TAGW-1:0]     pred_tag;
  logic                resolve_valid = 1'b0;
  logic [TAGW-1:0]     resolve_tag = '0;
  logic                resolve_taken = 1'b0;
  logic                flush = 1'b0;
  logic [GHR_SIZE-1:0] fghr;
  logic [GHR_SIZE-1:0] rghr;
  logic                redirect;
  logic [TAGW:0]       count;
  logic                err;

  always #5 clk = ~clk;

  el2_ifu_ghr_ctl #(.GHR_SIZE(GHR_SIZE), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_l(rst_l),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .pred_tag(pred_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_taken(resolve_taken), .flush(flush),
    .fghr(fghr), .rghr(rghr), .redirect(redirect), .count(count), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: histories as integers, outstanding predictions as a queue.
  int m_fg = 0, m_rg = 0, m_head = 0, m_tail = 0, m_redir = 0, m_err = 0;
  bit m_q[$];

  function automatic int hist(input int g, input bit b);
    return (g * 2 + int'(b)) % (1 << GHR_SIZE);
  endfunction

  task automatic model_step();
    bit acc, bad, good;
    if (!rst_l) begin
      m_fg = 0; m_rg = 0; m_head = 0; m_tail = 0; m_redir = 0; m_err = 0;
      m_q.delete();
      return;
    end
    acc  = pred_valid && (m_q.size() != DEPTH);
    bad  = resolve_valid && (m_q.size() == 0 || int'(resolve_tag) != m_head);
    good = resolve_valid && !bad;
    if (bad && !flush) m_err = 1;
    if (flush) begin
      m_fg = m_rg; m_q.delete(); m_head = m_tail; m_redir = 0;
    end else if (good && resolve_taken != m_q[0]) begin
      m_rg = hist(m_rg, resolve_taken); m_fg = m_rg;
      m_q.delete(); m_head = m_tail; m_redir = 1;
    end else begin
      if (good) begin
        m_rg = hist(m_rg, resolve_taken);
        void'(m_q.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (acc) begin
        m_fg = hist(m_fg, pred_taken);
        m_q.push_back(pred_taken);
        m_tail = (m_tail + 1) % DEPTH;
      end
      m_redir = 0;
    end
  endtask

  // Compare at mid-cycle, then advance the model with the inputs held to the next edge.
  initial forever begin
    @(negedge clk);
    chk("m_fghr", 32'(fghr), 32'(m_fg));
    chk("m_rghr", 32'(rghr), 32'(m_rg));
    chk("m_count", 32'(count), 32'(m_q.size()));
    chk("m_pred_ready", 32'(pred_ready), 32'(m_q.size() != DEPTH));
    chk("m_redirect", 32'(redirect), 32'(m_redir));
    chk("m_err", 32'(err), 32'(m_err));
    if (pred_valid && pred_ready) chk("m_pred_tag", 32'(pred_tag), 32'(m_tail));
    model_step();
  end

  task automatic drive(input bit pv, input bit pt, input bit rv, input int rtag,
                       input bit rt, input bit fl);
    pred_valid = pv; pred_taken = pt; resolve_valid = rv;
    resolve_tag = TAGW'(rtag); resolve_taken = rt; flush = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  bit pat[4] = '{1, 0, 1, 1};

  initial begin
    // Reset held for two edges with random inputs
    repeat (2) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom));
      cyc();
    end
    rst_l = 1'b1;
    idle();
    chk("rst_fghr", 32'(fghr), 32'h00);
    chk("rst_rghr", 32'(rghr), 32'h00);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(pred_ready), 1);
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_err", 32'(err), 0);

    // Fill with T,N,T,T
    for (int i = 0; i < 4; i++) begin
      drive(1, pat[i], 0, 0, 0, 0);
      chk("fill_tag", 32'(pred_tag), 32'(i));
      cyc();
    end
    idle();
    chk("fill_fghr", 32'(fghr), 32'h0B);
    chk("fill_count", 32'(count), 4);
    chk("fill_ready", 32'(pred_ready), 0);
    drive(1, 1, 0, 0, 0, 0);
    cyc();
    idle();
    chk("full_ignored_fghr", 32'(fghr), 32'h0B);

    // Correct retirement of tags 0..3
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, i, pat[i], 0);
      cyc();
      chk("retire_redirect", 32'(redirect), 0);
      if (i == 0) chk("retire_ready", 32'(pred_ready), 1);
    end
    idle();
    chk("retire_rghr", 32'(rghr), 32'h0B);
    chk("retire_count", 32'(count), 0);

    // Mispredict with a same-cycle prediction that must be dropped
    drive(1, 1, 0, 0, 0, 0); cyc();
    drive(1, 1, 0, 0, 0, 0); cyc();
    chk("mp_pre_fghr", 32'(fghr), 32'h2F);
    drive(1, 1, 1, 0, 0, 0); cyc();
    idle();
    chk("mp_rghr", 32'(rghr), 32'h16);
    chk("mp_fghr", 32'(fghr), 32'h16);
    chk("mp_count", 32'(count), 0);
    chk("mp_redirect", 32'(redirect), 1);
    cyc();
    chk("mp_redirect_drop", 32'(redirect), 0);

    // Flush with three outstanding and a same-cycle resolution (head tag is 2)
    repeat (3) begin drive(1, 1, 0, 0, 0, 0); cyc(); end
    chk("fl_pre_fghr", 32'(fghr), 32'hB7);
    drive(0, 0, 1, 2, 1, 1); cyc();
    idle();
    chk("fl_fghr", 32'(fghr), 32'h16);
    chk("fl_rghr", 32'(rghr), 32'h16);
    chk("fl_count", 32'(count), 0);

    // Protocol error: resolve with nothing outstanding
    drive(0, 0, 1, 1, 1, 0); cyc();
    idle();
    chk("pe_empty_err", 32'(err), 1);
    chk("pe_empty_rghr", 32'(rghr), 32'h16);
    drive(1, 1, 0, 0, 0, 0); cyc();
    drive(0, 0, 1, 1, 1, 0); cyc();
    idle();
    chk("pe_traffic_rghr", 32'(rghr), 32'h2D);
    chk("pe_sticky_err", 32'(err), 1);
    rst_l = 1'b0; cyc();
    rst_l = 1'b1;
    chk("pe_reset_err", 32'(err), 0);

    // Protocol error: tag mismatch against head 0
    drive(1, 1, 0, 0, 0, 0); cyc();
    drive(0, 0, 1, 1, 1, 0); cyc();
    idle();
    chk("pe_tag_err", 32'(err), 1);
    chk("pe_tag_rghr", 32'(rghr), 32'h00);
    chk("pe_tag_count", 32'(count), 1);

    repeat (2) cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
